// File: rtl/somador_serial_pkg.sv
// Shared definitions for the bit-serial adder: FSM encoding and legal WIDTH range.
// Optional signed-overflow output is enabled with SOMADOR_SERIAL_OVF_EN.
package somador_serial_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  localparam int WIDTH_MIN     = 2;
  localparam int WIDTH_MAX     = 32;
  localparam int WIDTH_DEFAULT = 8;

endpackage

// File: rtl/somador_serial_if.sv
// Operand/result handshake bundle for somador_serial; ovf exists only with SOMADOR_SERIAL_OVF_EN.
// Both sides follow valid/ready: a transfer happens at a rising edge where valid && ready; the
// source holds its payload stable while valid is high and ready is low.
interface somador_serial_if #(
  parameter int WIDTH = 8
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] R;
  logic             Cout;
`ifdef SOMADOR_SERIAL_OVF_EN
  logic             ovf;
`endif

  modport master (
    output in_valid, A, B, cin, out_ready,
    input  in_ready, out_valid, R, Cout
`ifdef SOMADOR_SERIAL_OVF_EN
    , input ovf
`endif
  );

  modport slave (
    input  in_valid, A, B, cin, out_ready,
    output in_ready, out_valid, R, Cout
`ifdef SOMADOR_SERIAL_OVF_EN
    , output ovf
`endif
  );

endinterface

// File: rtl/somador_completo_bit.sv
// One-bit full adder built from two half adders with the carries ORed.
module somador_completo_bit (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic s_o,
  output logic co_o
);

  logic s1;
  logic c1;
  logic c2;

  somador_meio u_ha0 (
    .a_i (a_i),
    .b_i (b_i),
    .s_o (s1),
    .c_o (c1)
  );

  somador_meio u_ha1 (
    .a_i (s1),
    .b_i (c_i),
    .s_o (s_o),
    .c_o (c2)
  );

  assign co_o = c1 | c2;

endmodule

// File: rtl/somador_meio.sv
// Half adder: the basic building block shared by the ULA adders.
module somador_meio (
  input  logic a_i,
  input  logic b_i,
  output logic s_o,
  output logic c_o
);

  assign s_o = a_i ^ b_i;
  assign c_o = a_i & b_i;

endmodule

// File: rtl/somador_serial.sv
// Bit-serial WIDTH-bit adder: one full-adder slice reused over WIDTH clocks with a registered carry.
// Define SOMADOR_SERIAL_OVF_EN to add the signed-overflow flag (bus.ovf).
module somador_serial
  import somador_serial_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  somador_serial_if.slave    bus,
  output state_e             state_o
);

  localparam int              CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_sh_q, a_sh_d;
  logic [WIDTH-1:0]   b_sh_q, b_sh_d;
  logic [WIDTH-1:0]   r_q, r_d;
  logic               carry_q, carry_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               fa_s;
  logic               fa_co;
`ifdef SOMADOR_SERIAL_OVF_EN
  logic               ovf_q, ovf_d;
`endif

  somador_completo_bit u_fa (
    .a_i  (a_sh_q[0]),
    .b_i  (b_sh_q[0]),
    .c_i  (carry_q),
    .s_o  (fa_s),
    .co_o (fa_co)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      r_q     <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
`ifdef SOMADOR_SERIAL_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      r_q     <= r_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
`ifdef SOMADOR_SERIAL_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    r_d     = r_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
`ifdef SOMADOR_SERIAL_OVF_EN
    ovf_d   = ovf_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (bus.in_valid) begin
          a_sh_d  = bus.A;
          b_sh_d  = bus.B;
          carry_d = bus.cin;
          cnt_d   = '0;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        // Sum bits enter at the MSB so after WIDTH shifts bit 0 sits at R[0].
        r_d     = {fa_s, r_q[WIDTH-1:1]};
        carry_d = fa_co;
        a_sh_d  = {1'b0, a_sh_q[WIDTH-1:1]};
        b_sh_d  = {1'b0, b_sh_q[WIDTH-1:1]};
        if (cnt_q == CNT_LAST) begin
          state_d = ST_DONE;
`ifdef SOMADOR_SERIAL_OVF_EN
          ovf_d   = carry_q ^ fa_co;
`endif
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DONE: begin
        if (bus.out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.in_ready  = (state_q == ST_IDLE);
  assign bus.out_valid = (state_q == ST_DONE);
  assign bus.R         = r_q;
  assign bus.Cout      = carry_q;
`ifdef SOMADOR_SERIAL_OVF_EN
  assign bus.ovf       = (state_q == ST_DONE) & ovf_q;
`endif
  assign state_o       = state_q;

endmodule

// File: tb/tb_somador_serial.sv
// Directed bench for somador_serial: WIDTH=8 vectors, backpressure and reset abort, plus a WIDTH=4 sweep.
// Overflow checks are active when SOMADOR_SERIAL_OVF_EN is defined.
module tb_somador_serial;
  import somador_serial_pkg::*;

  logic   clk;
  logic   rst;
  state_e st8;
  state_e st4;
  int     n_checks;
  int     n_errors;

  somador_serial_if #(.WIDTH(8)) if8 ();
  somador_serial_if #(.WIDTH(4)) if4 ();

  somador_serial #(.WIDTH(8)) u_dut8 (
    .clk     (clk),
    .rst     (rst),
    .bus     (if8.slave),
    .state_o (st8)
  );

  somador_serial #(.WIDTH(4)) u_dut4 (
    .clk     (clk),
    .rst     (rst),
    .bus     (if4.slave),
    .state_o (st4)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One WIDTH=8 transaction; hold > 0 stalls out_ready in DONE while offering junk operands.
  task automatic txn8(input string tag, input logic [7:0] a, input logic [7:0] b, input logic c,
                      input logic [7:0] exp_r, input logic exp_co, input logic exp_ovf,
                      input int hold, input logic eager);
    int   lat;
    logic rdy_seen;
    check({tag, ".in_ready_idle"}, 32'(if8.in_ready), 32'd1);
    if8.A        = a;
    if8.B        = b;
    if8.cin      = c;
    if8.in_valid = 1'b1;
    tick();
    if8.in_valid  = 1'b0;
    if8.A         = 8'($urandom_range(0, 255));
    if8.B         = 8'($urandom_range(0, 255));
    if8.cin       = 1'($urandom_range(0, 1));
    if8.out_ready = eager;
    lat      = 0;
    rdy_seen = 1'b0;
    while (!if8.out_valid && lat < 20) begin
      rdy_seen = rdy_seen | if8.in_ready;
      tick();
      lat++;
    end
    check({tag, ".in_ready_shift"}, 32'(rdy_seen), 32'd0);
    check({tag, ".latency"}, 32'(lat), 32'd8);
    check({tag, ".R"}, 32'(if8.R), 32'(exp_r));
    check({tag, ".Cout"}, 32'(if8.Cout), 32'(exp_co));
    check({tag, ".in_ready_done"}, 32'(if8.in_ready), 32'd0);
`ifdef SOMADOR_SERIAL_OVF_EN
    check({tag, ".ovf"}, 32'(if8.ovf), 32'(exp_ovf));
`else
    if (exp_ovf === 1'bx) $display("unexpected x in ovf vector");
`endif
    for (int i = 0; i < hold; i++) begin
      if8.in_valid = 1'b1;
      if8.A        = 8'hEE;
      if8.B        = 8'h11;
      tick();
      check({tag, ".hold_valid"}, 32'(if8.out_valid), 32'd1);
      check({tag, ".hold_R"}, 32'(if8.R), 32'(exp_r));
      check({tag, ".hold_Cout"}, 32'(if8.Cout), 32'(exp_co));
      check({tag, ".hold_in_ready"}, 32'(if8.in_ready), 32'd0);
    end
    if8.in_valid  = 1'b0;
    if8.out_ready = 1'b1;
    tick();
    if8.out_ready = 1'b0;
    check({tag, ".out_valid_idle"}, 32'(if8.out_valid), 32'd0);
    check({tag, ".in_ready_back"}, 32'(if8.in_ready), 32'd1);
    check({tag, ".R_held_idle"}, 32'(if8.R), 32'(exp_r));
  endtask

  // One WIDTH=4 transaction against the arithmetic model A+B+cin.
  task automatic txn4(input logic [3:0] a, input logic [3:0] b, input logic c);
    int         lat;
    logic [4:0] exp_sum;
    exp_sum = 5'(a) + 5'(b) + 5'(c);
    if4.A        = a;
    if4.B        = b;
    if4.cin      = c;
    if4.in_valid = 1'b1;
    tick();
    if4.in_valid = 1'b0;
    if4.A        = ~a;
    if4.B        = ~b;
    lat = 0;
    while (!if4.out_valid && lat < 12) begin
      tick();
      lat++;
    end
    check("sweep4.latency", 32'(lat), 32'd4);
    check("sweep4.sum", 32'({if4.Cout, if4.R}), 32'(exp_sum));
`ifdef SOMADOR_SERIAL_OVF_EN
    check("sweep4.ovf", 32'(if4.ovf), 32'((a[3] == b[3]) && (exp_sum[3] != a[3])));
`endif
    if4.out_ready = 1'b1;
    tick();
    if4.out_ready = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst = 1'b1;
    if8.in_valid = 1'b0; if8.A = '0; if8.B = '0; if8.cin = 1'b0; if8.out_ready = 1'b0;
    if4.in_valid = 1'b0; if4.A = '0; if4.B = '0; if4.cin = 1'b0; if4.out_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    check("reset.state", 32'(st8), 32'(ST_IDLE));
    check("reset.in_ready", 32'(if8.in_ready), 32'd1);
    check("reset.out_valid", 32'(if8.out_valid), 32'd0);
    check("reset.R", 32'(if8.R), 32'd0);
    check("reset.Cout", 32'(if8.Cout), 32'd0);
`ifdef SOMADOR_SERIAL_OVF_EN
    check("reset.ovf", 32'(if8.ovf), 32'd0);
`endif

    txn8("zero",   8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 0, 1'b0);
    txn8("ff_p1",  8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b0);
    txn8("a5_5a",  8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1, 1'b0, 0, 1'b1);
    txn8("7f_p1",  8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 0, 1'b0);
    txn8("80_80",  8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1, 0, 1'b0);
    txn8("c8_c8",  8'hC8, 8'hC8, 1'b1, 8'h91, 1'b1, 1'b0, 0, 1'b1);
    txn8("bkpr",   8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0, 5, 1'b0);

    // Abort a transaction with reset while bit 3 is being processed.
    if8.A = 8'h55; if8.B = 8'h0F; if8.cin = 1'b1; if8.in_valid = 1'b1;
    tick();
    if8.in_valid = 1'b0;
    tick(); tick(); tick();
    check("abort.state_shift", 32'(st8), 32'(ST_SHIFT));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort.state", 32'(st8), 32'(ST_IDLE));
    check("abort.out_valid", 32'(if8.out_valid), 32'd0);
    check("abort.R", 32'(if8.R), 32'd0);
    check("abort.Cout", 32'(if8.Cout), 32'd0);
    txn8("after_rst", 8'h03, 8'h04, 1'b0, 8'h07, 1'b0, 1'b0, 0, 1'b0);

    for (int c = 0; c < 2; c++)
      for (int a = 0; a < 16; a++)
        for (int b = 0; b < 16; b++)
          txn4(4'(a), 4'(b), 1'(c));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
